// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 7-segment display path: FSM states,
// segment lookup table, digit-enable encodings and the BCD adjust step.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam int         DIG_IDX_W   = 2;
  localparam logic [2:0] DIG_EN_NONE = 3'b000;
  localparam logic [2:0] DIG_EN_ONES = 3'b001;
  localparam logic [2:0] DIG_EN_TENS = 3'b010;
  localparam logic [2:0] DIG_EN_HUND = 3'b100;

  // Double-dabble pre-shift correction: +3 on every nibble that is 5 or more.
  function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int n = 0; n < 3; n++) begin
      if (b[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = b[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_lut_encode.sv
// Combinational digit-to-segment encoder, active-high {g,f,e,d,c,b,a}.
// Digits above 9, or a blank request, produce an unlit pattern.
module seg7_lut_encode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank && (i_digit <= 4'd9)) o_seg = SEG_LUT[i_digit];
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 3-digit 7-segment controller: sequential binary-to-BCD conversion behind a
// load handshake, plus a free-running digit scan with registered outputs.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  value_i,
  input  logic        load_i,
  output logic        busy_o,
  output logic [11:0] bcd_o,
  output logic [6:0]  seg_o,
  output logic [2:0]  dig_en_o,
  output logic [1:0]  dbg_state_o
);

  localparam int         PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [2:0] DIG_OFF = {3{SEG_ACTIVE_LOW}};

  // Handshake: a load is taken on a rising edge where load_i=1 and busy_o=0;
  // anything offered while busy_o=1 is silently dropped.
  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [7:0]             r_bin;
  logic [11:0]            r_scr;
  logic [3:0]             r_cnt;
  logic                   r_busy;
  logic [11:0]            r_bcd;
  logic [11:0]            w_adj;

  logic [PW-1:0]          r_presc;
  logic [PW-1:0]          w_presc_nxt;
  logic [DIG_IDX_W-1:0]   r_slot;
  logic [DIG_IDX_W-1:0]   w_slot_nxt;
  logic                   w_wrap;
  logic [3:0]             w_digit;
  logic                   w_blank;
  logic [2:0]             w_en;
  logic [6:0]             w_seg;
  logic [6:0]             r_seg;
  logic [2:0]             r_dig_en;

  assign w_adj = bcd_adjust(r_scr);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (load_i) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == 4'd1) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bin   <= 8'd0;
      r_scr   <= 12'd0;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_bcd   <= 12'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (load_i) begin
          r_bin  <= value_i;
          r_scr  <= 12'd0;
          r_cnt  <= 4'd8;
          r_busy <= 1'b1;
        end
        SHIFT: begin
          {r_scr, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt - 4'd1;
        end
        COMMIT: begin
          r_bcd  <= r_scr;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next scan position so they line up with
  // the prescaler/slot registers they describe.
  always_comb begin
    w_wrap      = (r_presc == PW'(SCAN_DIV - 1));
    w_presc_nxt = w_wrap ? '0 : r_presc + 1'b1;
    w_slot_nxt  = r_slot;
    if (w_wrap) w_slot_nxt = (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;
  end

  always_comb begin
    w_digit = r_bcd[3:0];
    w_blank = 1'b0;
    w_en    = DIG_EN_ONES;
    case (w_slot_nxt)
      2'd0: begin
        w_digit = r_bcd[3:0];
        w_en    = DIG_EN_ONES;
      end
      2'd1: begin
        w_digit = r_bcd[7:4];
        w_blank = BLANK_LEADING && (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
        w_en    = DIG_EN_TENS;
      end
      2'd2: begin
        w_digit = r_bcd[11:8];
        w_blank = BLANK_LEADING && (r_bcd[11:8] == 4'd0);
        w_en    = DIG_EN_HUND;
      end
      default: begin
        w_blank = 1'b1;
        w_en    = DIG_EN_NONE;
      end
    endcase
    // First cycle of every slot is dark to avoid ghosting across digits.
    if (w_presc_nxt == '0) w_en = DIG_EN_NONE;
  end

  seg7_lut_encode u_enc (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc  <= '0;
      r_slot   <= '0;
      r_seg    <= SEG_OFF;
      r_dig_en <= DIG_OFF;
    end else begin
      r_presc  <= w_presc_nxt;
      r_slot   <= w_slot_nxt;
      r_seg    <= w_seg ^ SEG_OFF;
      r_dig_en <= w_en ^ DIG_OFF;
    end
  end

  assign busy_o      = r_busy;
  assign bcd_o       = r_bcd;
  assign seg_o       = r_seg;
  assign dig_en_o    = r_dig_en;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: an active-high instance and an
// active-low instance share clock and reset.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  value = 8'd0;
  logic        load = 1'b0;
  logic        busy;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  dig_en;
  logic [1:0]  dbg;
  logic [7:0]  value_al = 8'd0;
  logic        load_al = 1'b0;
  logic        busy_al;
  logic [11:0] bcd_al;
  logic [6:0]  seg_al;
  logic [2:0]  dig_al;
  logic [1:0]  dbg_al;

  int test_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load), .busy_o(busy),
    .bcd_o(bcd), .seg_o(seg), .dig_en_o(dig_en), .dbg_state_o(dbg)
  );

  seven_seg_scan_ctrl #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .value_i(value_al), .load_i(load_al), .busy_o(busy_al),
    .bcd_o(bcd_al), .seg_o(seg_al), .dig_en_o(dig_al), .dbg_state_o(dbg_al)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] golden_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic wait_pat(input bit al, input logic [2:0] pat, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if ((al ? dig_al : dig_en) === pat) found = 1'b1;
      else tick();
    end
    chk({tag, "_reached"}, 32'(found), 32'd1);
  endtask

  task automatic check_slot(input bit al, input logic [2:0] pat, input logic [6:0] exp_seg,
                            input string tag);
    tick();
    wait_pat(al, pat, tag);
    chk(tag, 32'(al ? seg_al : seg), 32'(exp_seg));
  endtask

  task automatic load_main(input logic [7:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      tick();
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h000);
    chk("rst_seg", 32'(seg), 32'h00);
    chk("rst_dig", 32'(dig_en), 32'h0);
    chk("rst_state", 32'(dbg), 32'd0);
    chk("rst_al_seg", 32'(seg_al), 32'h7F);
    chk("rst_al_dig", 32'(dig_al), 32'h7);
    rst_n = 1'b1;

    // Load 255: busy through E0..E8, commit at E9
    load_main(8'd255);
    chk("t2_busy_e0", 32'(busy), 32'd1);
    chk("t2_state_shift", 32'(dbg), 32'd1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("t2_busy_mid", 32'(busy), 32'd1);
    end
    chk("t2_bcd_pending", 32'(bcd), 32'h000);
    tick();
    chk("t2_busy_e9", 32'(busy), 32'd0);
    chk("t2_bcd", 32'(bcd), 32'h255);
    check_slot(1'b0, 3'b001, 7'h6D, "t2_ones");
    check_slot(1'b0, 3'b010, 7'h6D, "t2_tens");
    check_slot(1'b0, 3'b100, 7'h5B, "t2_hund");

    // Reset mid-conversion and mid-scan
    load_main(8'd123);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t1_seg", 32'(seg), 32'h00);
    chk("t1_dig", 32'(dig_en), 32'h0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_bcd", 32'(bcd), 32'h000);
    chk("t1_al_seg", 32'(seg_al), 32'h7F);
    chk("t1_al_dig", 32'(dig_al), 32'h7);
    tick();
    #2 rst_n = 1'b1;
    check_slot(1'b0, 3'b001, 7'h3F, "t1_ones");
    check_slot(1'b0, 3'b010, 7'h00, "t1_tens");
    check_slot(1'b0, 3'b100, 7'h00, "t1_hund");
    chk("t1_bcd_after", 32'(bcd), 32'h000);

    // Sweep every input value against the golden decimal split
    for (int v = 0; v < 256; v++) begin
      load_main(8'(v));
      wait_idle("t3_idle");
      chk("t3_bcd", 32'(bcd), 32'(golden_bcd(v)));
    end

    // Load while busy is dropped; a load at E10 is taken
    load_main(8'd7);
    tick();
    tick();
    value = 8'd200;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    chk("t4_busy_e3", 32'(busy), 32'd1);
    repeat (5) tick();
    chk("t4_busy_e8", 32'(busy), 32'd1);
    tick();
    chk("t4_busy_e9", 32'(busy), 32'd0);
    chk("t4_bcd_7", 32'(bcd), 32'h007);
    load_main(8'd200);
    chk("t4_busy_e10", 32'(busy), 32'd1);
    repeat (9) tick();
    chk("t4_busy_e19", 32'(busy), 32'd0);
    chk("t4_bcd_200", 32'(bcd), 32'h200);

    // Scan timing over 24 cycles, starting at the dark cycle of the ones slot
    wait_pat(1'b0, 3'b100, "t5_sync_hund");
    wait_pat(1'b0, 3'b000, "t5_sync_dark");
    for (int k = 0; k < 24; k++) begin
      logic [2:0] exp_en;
      logic [6:0] exp_seg;
      int         slot;
      slot    = (k / 4) % 3;
      exp_en  = ((k % 4) == 0) ? 3'b000 : 3'(1 << slot);
      exp_seg = (slot == 2) ? 7'h5B : 7'h3F;
      chk("t5_dig", 32'(dig_en), 32'(exp_en));
      chk("t5_seg", 32'(seg), 32'(exp_seg));
      tick();
    end

    // Active-low instance showing 105
    value_al = 8'd105;
    load_al  = 1'b1;
    tick();
    load_al  = 1'b0;
    repeat (10) tick();
    chk("t6_busy", 32'(busy_al), 32'd0);
    chk("t6_bcd", 32'(bcd_al), 32'h105);
    check_slot(1'b1, 3'b101, 7'h40, "t6_tens");
    check_slot(1'b1, 3'b110, 7'h12, "t6_ones");
    check_slot(1'b1, 3'b011, 7'h79, "t6_hund");

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
